// File: rtl/seq_shift_pkg.sv
// Shared definitions for the iterative shifter and its ALU neighbours:
// op codes and FSM state encoding.
package seq_shift_pkg;

    localparam logic [1:0] SH_SLL_A = 2'b00;
    localparam logic [1:0] SH_SLL   = 2'b01;
    localparam logic [1:0] SH_SRA   = 2'b10;
    localparam logic [1:0] SH_SRL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [5:0] step_amt(
        input logic [5:0] cnt,
        input logic [5:0] step
    );
        return (cnt < step) ? cnt : step;
    endfunction

endpackage

// File: rtl/seq_shifter32_step.sv
// Combinational single-step shifter: shifts acc by k (0..STEP) per op.
module shift_step
    import seq_shift_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [5:0]  k,
    input  logic [1:0]  op,
    output logic [31:0] res
);

    always_comb begin
        res = acc;
        unique case (op)
            SH_SLL_A, SH_SLL: res = acc << k;
            SH_SRA:           res = $unsigned($signed(acc) >>> k);
            SH_SRL:           res = acc >> k;
            default:          res = acc;
        endcase
    end

endmodule

// File: rtl/seq_shifter32.sv
// Multi-cycle shift unit: up to STEP bits per cycle behind a
// start/busy/done handshake, with a registered, held result.
module seq_shifter32
    import seq_shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  ctr,
    output logic        busy,
    output logic        done,
    output logic [31:0] d
);

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      state;
    logic [31:0] acc;
    logic [31:0] shifted;
    logic [5:0]  cnt;
    logic [5:0]  k;
    logic [1:0]  op;

    // k never exceeds the remaining count, so the last step is partial
    assign k = step_amt(cnt, STEP_W);

    shift_step u_step (
        .acc (acc),
        .k   (k),
        .op  (op),
        .res (shifted)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            op    <= SH_SLL_A;
            d     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= a;
                        cnt  <= {1'b0, b};
                        op   <= ctr;
                        busy <= 1'b1;
                        if (b == 5'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            d     <= a;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= shifted;
                    cnt <= cnt - k;
                    if (cnt <= STEP_W) begin
                        state <= DONE;
                        done  <= 1'b1;
                        d     <= shifted;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
